mult8_rr_arbiter: RTL

MULT8_RR_ARBITER -- requirements
Module: mult8_rr_arbiter

---
 rtl/mult8_rr_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mult8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult8_rr_arbiter
//
// Shares one 8x8 unsigned multiplier between NREQ requesters. A round-robin
// arbiter picks one valid requester per cycle, its operands go through the
// shared multiplier, and the 16-bit product is captured in a single-entry
// response register together with the requester index. The response register
// is a two-state (EMPTY/FULL) buffer that can be drained and refilled in the
// same cycle, so a continuously ready consumer sees one product per cycle.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   IDW   requester-index width, ceil(log2(NREQ))
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   [NREQ]    requester k presents operands
//   req_ready_o   [NREQ]    one-hot grant, combinational
//   operand1_i    [8*NREQ]  first operand of requester k in [8k+7:8k]
//   operand2_i    [8*NREQ]  second operand of requester k in [8k+7:8k]
//   rsp_valid_o             response register holds a product
//   rsp_ready_i             consumer takes the response this cycle
//   rsp_id_o      [IDW]     requester that owns the held product
//   result_o      [16]      held unsigned product
//   done_cnt_o    [16]      responses consumed, wraps at 0xFFFF
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// traditional_multiplier8
//
// Purely combinational 8x8 unsigned shift-and-add multiplier: every set bit
// of b adds a shifted copy of a into a 16-bit accumulator, so the full
// product is kept with no truncation.
//
// Ports
//   a  [8]   multiplicand
//   b  [8]   multiplier
//   p  [16]  unsigned product a*b
// ---------------------------------------------------------------------------
module traditional_multiplier8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  always_comb begin
    // NOTE: combinational accumulation uses blocking '=' so each loop pass
    // sees the partial sum of the previous one; a default comes first so no
    // path leaves p unassigned (which would infer a latch).
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p + (16'(a) << i);
      end
    end
  end

endmodule

module mult8_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [8*NREQ-1:0] operand1_i,
  input  logic [8*NREQ-1:0] operand2_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [15:0]       result_o,
  output logic [15:0]       done_cnt_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int CW = IDW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q;
  state_e         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_next;

  logic           accept;
  logic           grant;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  logic [7:0]     mul_a;
  logic [7:0]     mul_b;
  logic [15:0]    product;

  // -------------------------------------------------------------------------
  // Accept: the response register can take a new product when it is empty
  // or is being drained in this same cycle.
  // -------------------------------------------------------------------------
  assign accept = (state_q == EMPTY) || rsp_ready_i;

  // -------------------------------------------------------------------------
  // Round-robin search: start at ptr, wrap modulo NREQ, take the first valid
  // requester. Only the current valid bits matter, so a requester that drops
  // out before being served leaves no trace.
  // -------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [CW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!grant_found && req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Reset gating keeps the grant silent while the block is held in reset.
  assign grant = grant_found && accept && rst_ni;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // The winner of the search becomes the lowest priority next time.
  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // -------------------------------------------------------------------------
  // Operand mux into the shared multiplier
  // -------------------------------------------------------------------------
  assign mul_a = operand1_i[{grant_idx, 3'b000} +: 8];
  assign mul_b = operand2_i[{grant_idx, 3'b000} +: 8];

  traditional_multiplier8 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (product)
  );

  // -------------------------------------------------------------------------
  // Output FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // A grant here implies rsp_ready_i: drain and refill together.
        if (grant) begin
          state_d = FULL;
        end else if (rsp_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output FSM: output logic
  always_comb begin
    rsp_valid_o = (state_q == FULL);
  end

  // -------------------------------------------------------------------------
  // Response register and round-robin pointer. Both load only on a grant, so
  // the held product and id stay put under backpressure and while EMPTY.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      rsp_id_o <= '0;
      ptr_q    <= '0;
    end else if (grant) begin
      result_o <= product;
      rsp_id_o <= grant_idx;
      ptr_q    <= ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Completed-response counter; natural 16-bit wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_cnt_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i) begin
      done_cnt_o <= done_cnt_o + 16'd1;
    end
  end

endmodule
